// File: rtl/pc_shift_pipe.sv
// PC shift pipeline with flush/kill, post-flush freeze and an optional return-address
// register for the oldest stage (enabled by macro PC_SHIFT_PIPE_LINK_EN).
module pc_shift_pipe #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 3,
  parameter int KILL     = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       pc_in,
  input  logic                   pc_valid_in,
  output logic [WIDTH*DEPTH-1:0] pc_stages,
  output logic [DEPTH-1:0]       valid_stages,
  output logic [WIDTH-1:0]       link_out,
  output logic                   hold_busy
);

  localparam logic [1:0] HOLD_INIT = 2'(HOLD_CYC);

  logic [WIDTH-1:0] pc_q [DEPTH];
  logic [WIDTH-1:0] pc_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [1:0]       hold_q, hold_d;
  logic             advance, flush_acc;

  always_comb begin
    hold_busy = (hold_q != 2'd0);
    advance   = !stall && !hold_busy;
    flush_acc = flush && !hold_busy;
    pc_d      = pc_q;
    vld_d     = vld_q;
    hold_d    = hold_busy ? hold_q - 2'd1 : hold_q;
    // Accepted flush beats stall: killed stages clear, older ones still shift.
    if (flush_acc) begin
      hold_d   = HOLD_INIT;
      pc_d[0]  = '0;
      vld_d[0] = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (i < KILL) begin
          pc_d[i]  = '0;
          vld_d[i] = 1'b0;
        end else begin
          pc_d[i]  = pc_q[i-1];
          vld_d[i] = vld_q[i-1];
        end
      end
    end else if (advance) begin
      pc_d[0]  = pc_in;
      vld_d[0] = pc_valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        pc_d[i]  = pc_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      vld_q  <= '0;
      hold_q <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= pc_d[i];
      vld_q  <= vld_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    pc_stages = '0;
    for (int i = 0; i < DEPTH; i++) pc_stages[i*WIDTH +: WIDTH] = pc_q[i];
  end

  assign valid_stages = vld_q;

`ifdef PC_SHIFT_PIPE_LINK_EN
  logic [WIDTH-1:0] link_q, link_d;
  logic             upd_last;

  // The oldest stage changes on every advance or accepted flush.
  always_comb begin
    upd_last = advance || flush_acc;
    link_d   = link_q;
    if (upd_last) link_d = vld_d[DEPTH-1] ? pc_d[DEPTH-1] + WIDTH'(4) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) link_q <= '0;
    else     link_q <= link_d;
  end

  assign link_out = link_q;
`else
  assign link_out = '0;
`endif

endmodule
